// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// One shift-right-and-correct step per clock; start/completed handshake.
module bcd_to_binary #(
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned BIN_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*DIGITS-1:0]    bcd,
    output logic [BIN_WIDTH-1:0]   binary,
    output logic                   completed,
    output logic                   busy,
    output logic                   error
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_WIDTH;
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SR_W-1:0]        sreg_q, sreg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   invalid_q, invalid_d;
    logic [BIN_WIDTH-1:0]   binary_q, binary_d;
    logic                   completed_q, completed_d;
    logic                   busy_q, busy_d;
    logic                   error_q, error_d;

    logic                   bcd_bad;
    logic [SR_W-1:0]        shifted;
    logic [SR_W-1:0]        step;

    // Any nibble above 9 makes the whole input invalid.
    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] > 4'd9) begin
                bcd_bad = 1'b1;
            end
        end
    end

    // One reverse double-dabble iteration: shift right, then correct digits >= 8.
    always_comb begin
        shifted = sreg_q >> 1;
        step    = shifted;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (shifted[BIN_WIDTH + 4*i +: 4] >= 4'd8) begin
                step[BIN_WIDTH + 4*i +: 4] = shifted[BIN_WIDTH + 4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        invalid_d   = invalid_q;
        binary_d    = binary_q;
        completed_d = 1'b0;
        busy_d      = busy_q;
        error_d     = error_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    sreg_d    = {bcd, {BIN_WIDTH{1'b0}}};
                    cnt_d     = CNT_W'(BIN_WIDTH);
                    busy_d    = 1'b1;
                    invalid_d = bcd_bad;
                    state_d   = bcd_bad ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                sreg_d = step;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                completed_d = 1'b1;
                binary_d    = invalid_q ? '0 : sreg_q[BIN_WIDTH-1:0];
                error_d     = invalid_q;
                busy_d      = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            invalid_q   <= 1'b0;
            binary_q    <= '0;
            completed_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            invalid_q   <= invalid_d;
            binary_q    <= binary_d;
            completed_q <= completed_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign binary    = binary_q;
    assign completed = completed_q;
    assign busy      = busy_q;
    assign error     = error_q;

endmodule
